// File: rtl/led_bank_arbiter.sv
// Round-robin owner of the 5-LED bank: a requester keeps the bank for a minimum
// hold window, then yields to contenders through a single idle cycle.
module led_bank_arbiter #(
  parameter int         NUM_REQ      = 3,
  parameter int         HOLD_CNT     = 5_000_000,
  parameter logic [4:0] IDLE_PATTERN = 5'b00000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [5*NUM_REQ-1:0] pattern_in,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [4:0]           LED,
  output logic [4:0]           LED_en,
  output logic                 busy
);

  localparam int               CNT_W      = $clog2(HOLD_CNT + 1);
  localparam int               HOLD_LAST  = (HOLD_CNT >= 2) ? HOLD_CNT - 2 : 0;
  localparam logic [CNT_W-1:0] CNT_EXPIRE = CNT_W'(HOLD_LAST);
  localparam logic [1:0]       LAST_RST   = 2'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_SHARE
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [4:0]         led_q, led_d;
  logic [4:0]         led_en_q, led_en_d;
  logic               busy_q, busy_d;

  // Pad to the 4-requester maximum so 2-bit indices are always in range.
  logic [3:0]  req_pad;
  logic [19:0] pat_pad;
  logic [4:0]  owner_bit;
  logic        owner_req;
  logic        others_req;
  logic        found;
  logic [1:0]  sel;
  logic [2:0]  cand;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b0001 << idx;
    return v[NUM_REQ-1:0];
  endfunction

  assign req_pad    = 4'(req);
  assign pat_pad    = 20'(pattern_in);
  assign owner_bit  = 5'(owner_q) * 5'd5;
  assign owner_req  = |(req & gnt_q);
  assign others_req = |(req & ~gnt_q);

  // First requester at or after last+1, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + 3'(k);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      if (!found && req_pad[cand[1:0]]) begin
        found = 1'b1;
        sel   = cand[1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      last_q   <= LAST_RST;
      cnt_q    <= '0;
      gnt_q    <= '0;
      led_q    <= 5'b00000;
      led_en_q <= 5'b00000;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      led_q    <= led_d;
      led_en_q <= led_en_d;
      busy_q   <= busy_d;
    end
  end

  // The counter holds the number of completed hold cycles; leaving HOLD on the
  // edge that completes HOLD_CNT-1 lets a contender's preemption land exactly
  // HOLD_CNT cycles after the grant edge.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        if (found) begin
          owner_d = sel;
          last_d  = sel;
          gnt_d   = onehot(sel);
          cnt_d   = '0;
          state_d = (HOLD_CNT <= 1) ? S_SHARE : S_HOLD;
        end
      end
      S_HOLD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!owner_req) begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_EXPIRE) begin
          state_d = S_SHARE;
        end
      end
      S_SHARE: begin
        if (!owner_req || others_req) begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // LED follows the registered grant, so it trails gnt by one cycle.
  always_comb begin
    led_d    = (gnt_q != '0) ? pat_pad[owner_bit +: 5] : IDLE_PATTERN;
    led_en_d = 5'b11111;
    busy_d   = |gnt_d;
  end

  always_comb begin
    gnt    = gnt_q;
    LED    = led_q;
    LED_en = led_en_q;
    busy   = busy_q;
  end

endmodule
